// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU control
// and its sequenced multiplier.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_MUL = 3'b100,
      ALU_NOP = 3'b101
   } alu_ctrl_e;

   localparam logic [1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [1:0] ALUOP_ADD   = 2'b01;
   localparam logic [1:0] ALUOP_OR    = 2'b10;
   localparam logic [1:0] ALUOP_SUB   = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_MUL  = 6'b011000;
   localparam logic [5:0] FUNCT_MULU = 6'b011001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } mul_state_e;

   function automatic logic is_mul_funct(input logic [5:0] f);
      return (f == FUNCT_MUL) || (f == FUNCT_MULU);
   endfunction

endpackage

// File: rtl/alu_ctrl_mul_seq_if.sv
// alu_ctrl_mul_seq_if: EX-stage bundle between the ID/EX register,
// the ALU control/multiplier and the hazard unit.
interface alu_ctrl_mul_seq_if #(
   parameter int WIDTH = 32
);
   logic               valid_i;
   logic               flush_i;
   logic [5:0]         funct_i;
   logic [1:0]         ALUOp_i;
   logic [WIDTH-1:0]   opA_i;
   logic [WIDTH-1:0]   opB_i;
   logic [2:0]         ALUCtrl_o;
   logic               stall_o;
   logic               done_o;
   logic [2*WIDTH-1:0] prod_o;

   modport master (
      output valid_i, flush_i, funct_i, ALUOp_i, opA_i, opB_i,
      input  ALUCtrl_o, stall_o, done_o, prod_o
   );

   modport slave (
      input  valid_i, flush_i, funct_i, ALUOp_i, opA_i, opB_i,
      output ALUCtrl_o, stall_o, done_o, prod_o
   );
endinterface

// File: rtl/mul_iter_core.sv
// mul_iter_core: shift-add multiplier datapath retiring
// BITS_PER_CYCLE multiplier bits per step.
module mul_iter_core
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               step_i,
   input  logic               flush_i,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic               last_o,
   output logic [2*WIDTH-1:0] prod_nxt_o
);
   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam int HI_W  = WIDTH + BITS_PER_CYCLE;
   localparam int ACC_W = 2 * WIDTH + BITS_PER_CYCLE;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HI_W-1:0]  sum;

   // Upper part accumulates, lower part holds the unretired multiplier.
   always_comb begin
      sum = acc_q[ACC_W-1:WIDTH]
          + HI_W'(mcand_q) * HI_W'(acc_q[BITS_PER_CYCLE-1:0]);
      prod_nxt_o = {sum, acc_q[WIDTH-1:BITS_PER_CYCLE]};
   end

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         acc_d   = {{HI_W{1'b0}}, mplier_i};
         mcand_d = mcand_i;
         cnt_d   = '0;
      end else if (step_i) begin
         acc_d = {{BITS_PER_CYCLE{1'b0}}, prod_nxt_o};
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign last_o = (cnt_q == CNT_W'(STEPS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_ctrl_mul_seq.sv
// alu_ctrl_mul_seq: ALUCtrl decode plus sequenced multiplier with stall.
// Define ALU_CTRL_SIGNED_MUL_EN to make funct 011000 a signed multiply.
module alu_ctrl_mul_seq
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   alu_ctrl_mul_seq_if.slave bus
);
   localparam int PW = 2 * WIDTH;

   alu_ctrl_e        alu_ctrl;
   logic             is_mul;
   mul_state_e       state_q, state_d;
   logic             done_q, done_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic             core_start, core_step, core_flush, core_last;
   logic [WIDTH-1:0] mcand, mplier;
   logic [PW-1:0]    core_prod, prod_fix;

   always_comb begin
      alu_ctrl = ALU_NOP;
      unique case (bus.ALUOp_i)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_OR:  alu_ctrl = ALU_OR;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         default: begin
            unique case (1'b1)
               bus.funct_i == FUNCT_ADD:  alu_ctrl = ALU_ADD;
               bus.funct_i == FUNCT_SUB:  alu_ctrl = ALU_SUB;
               bus.funct_i == FUNCT_AND:  alu_ctrl = ALU_AND;
               bus.funct_i == FUNCT_OR:   alu_ctrl = ALU_OR;
               is_mul_funct(bus.funct_i): alu_ctrl = ALU_MUL;
               default:                   alu_ctrl = ALU_NOP;
            endcase
         end
      endcase
   end

   assign is_mul = bus.valid_i
                 & (bus.ALUOp_i == ALUOP_FUNCT)
                 & is_mul_funct(bus.funct_i);

`ifdef ALU_CTRL_SIGNED_MUL_EN
   logic sgn_op, neg_q, neg_d;

   // Core works on magnitudes; the sign is reapplied at completion.
   always_comb begin
      sgn_op = (bus.funct_i == FUNCT_MUL);
      mcand  = (sgn_op && bus.opA_i[WIDTH-1]) ? -bus.opA_i : bus.opA_i;
      mplier = (sgn_op && bus.opB_i[WIDTH-1]) ? -bus.opB_i : bus.opB_i;
      neg_d  = neg_q;
      if (core_start)
         neg_d = sgn_op & (bus.opA_i[WIDTH-1] ^ bus.opB_i[WIDTH-1]);
      prod_fix = neg_q ? -core_prod : core_prod;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) neg_q <= 1'b0;
      else       neg_q <= neg_d;
   end
`else
   always_comb begin
      mcand    = bus.opA_i;
      mplier   = bus.opB_i;
      prod_fix = core_prod;
   end
`endif

   // Flush outranks both acceptance and completion.
   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      prod_d     = prod_q;
      core_start = 1'b0;
      core_step  = 1'b0;
      core_flush = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (is_mul && !bus.flush_i) begin
               core_start = 1'b1;
               state_d    = ST_MUL;
            end
         end
         ST_MUL: begin
            if (bus.flush_i) begin
               core_flush = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               core_step = 1'b1;
               if (core_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  prod_d  = prod_fix;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end

   mul_iter_core #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (core_start),
      .step_i     (core_step),
      .flush_i    (core_flush),
      .mcand_i    (mcand),
      .mplier_i   (mplier),
      .last_o     (core_last),
      .prod_nxt_o (core_prod)
   );

   assign bus.ALUCtrl_o = alu_ctrl;
   assign bus.stall_o   = ~rst_i & ((state_q == ST_MUL)
                        | ((state_q == ST_IDLE) & is_mul));
   assign bus.done_o    = done_q;
   assign bus.prod_o    = prod_q;

endmodule
